// File: rtl/fetch2_wide_pkg.sv
// Shared types, opcode constants and predecode helpers for the fetch2_wide stage.
package fetch2_wide_pkg;

  typedef logic [31:0] u32_t;

  localparam logic [5:0] OPC_JIRL = 6'h13;
  localparam logic [5:0] OPC_B    = 6'h14;
  localparam logic [5:0] OPC_BL   = 6'h15;
  localparam logic [5:0] OPC_BEQ  = 6'h16;
  localparam logic [5:0] OPC_BNE  = 6'h17;
  localparam logic [5:0] OPC_BLT  = 6'h18;
  localparam logic [5:0] OPC_BGE  = 6'h19;
  localparam logic [5:0] OPC_BLTU = 6'h1A;
  localparam logic [5:0] OPC_BGEU = 6'h1B;

  localparam u32_t RET_INST = 32'h4C00_0020;

  typedef struct packed {
    logic is_br;
    logic is_b_bl;
    logic is_call;
    logic is_ret;
  } predecode_t;

  typedef struct packed {
    logic valid;
    u32_t pc;
    logic is_predict;
  } wr_pc_req_t;

  typedef struct packed {
    logic valid;
    u32_t pc;
  } btb_invalid_t;

  typedef struct packed {
    logic       valid;
    logic [5:0] ecode;
  } excp_pass_t;

  function automatic predecode_t predecode(input u32_t inst);
    predecode_t pd;
    pd        = '0;
    pd.is_ret = (inst == RET_INST);
    case (inst[31:26])
      OPC_JIRL, OPC_BEQ, OPC_BNE, OPC_BLT,
      OPC_BGE, OPC_BLTU, OPC_BGEU: pd.is_br = 1'b1;
      OPC_B:  begin pd.is_br = 1'b1; pd.is_b_bl = 1'b1; end
      OPC_BL: begin pd.is_br = 1'b1; pd.is_b_bl = 1'b1; pd.is_call = 1'b1; end
      default: ;
    endcase
    return pd;
  endfunction

  // B/BL carry offs[25:16] in inst[9:0] and offs[15:0] in inst[25:10].
  function automatic u32_t b_offset(input logic [25:0] offs_field);
    return {{4{offs_field[9]}}, offs_field[9:0], offs_field[25:10], 2'b00};
  endfunction

endpackage

// File: rtl/fetch2_wide_ras.sv
// Circular return-address stack: pushes beyond DEPTH overwrite the oldest entry.
module ras_circ
  import fetch2_wide_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic pop_i,
  input  u32_t push_addr_i,
  output u32_t top_o,
  output logic top_valid_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  u32_t          mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d, top_idx;
  logic [CW-1:0] cnt_q, cnt_d;

  assign top_idx     = ptr_q - PW'(1);
  assign top_o       = mem_q[top_idx];
  assign top_valid_o = (cnt_q != '0);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + PW'(1);
      if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
    end else if (pop_i && top_valid_o) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[ptr_q] <= push_addr_i;
  end

endmodule

// File: rtl/fetch2_wide.sv
// Second fetch stage, FETCH_W slots wide: predecode, BTB fix-up, early B/BL resolve, truncation.
// Define FETCH2_RAS_EN to add the return-address stack that repredicts returns.
module fetch2_wide
  import fetch2_wide_pkg::*;
#(
  parameter int FETCH_W   = 2,
  parameter int RAS_DEPTH = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          flush_i,
  input  logic                                          stall_i,
  output logic                                          stall_o,
  input  logic [32*FETCH_W-1:0]                         icache_data,
  input  logic                                          icache_data_valid,
  input  logic                                          in_valid,
  input  logic [31:0]                                   in_pc,
  input  logic                                          in_icache_req,
  input  logic                                          in_pred_valid,
  input  logic [((FETCH_W > 1) ? $clog2(FETCH_W) : 1)-1:0] in_pred_slot,
  input  logic [31:0]                                   in_pred_pc,
  input  excp_pass_t                                    excp_in,
  output logic                                          out_valid,
  output logic [31:0]                                   out_pc,
  output logic [FETCH_W-1:0]                            out_slot_mask,
  output logic [32*FETCH_W-1:0]                         out_inst,
  output logic [31:0]                                   out_next_pc,
  output logic                                          out_next_is_predict,
  output excp_pass_t                                    excp_out,
  output wr_pc_req_t                                    wr_pc_req,
  output btb_invalid_t                                  btb_invalid,
  output logic                                          bp_update_flush
);
  localparam int   SW       = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
  localparam u32_t OFF_MASK = 32'(4 * FETCH_W - 1);

  logic          valid_q, icache_req_q, pred_valid_q;
  u32_t          pc_q, pred_pc_q;
  logic [SW-1:0] pred_slot_q;
  excp_pass_t    excp_q;

  logic          icache_wait, fire;
  u32_t          base;
  logic [SW-1:0] s0, k, last;
  u32_t          inst    [FETCH_W];
  u32_t          slot_pc [FETCH_W];
  predecode_t    pd      [FETCH_W];
  logic          hit, bp_hit, call_hit, ret_hit, red_pred, next_pred;
  u32_t          red_pc, bp_pc, link_pc, next_pc;
  logic [FETCH_W-1:0] mask;
  u32_t          ras_top;
  logic          ras_valid;

  // ---- stage register: control is reset, payload only follows the load enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      icache_req_q <= 1'b0;
    end else if (flush_i) begin
      valid_q      <= 1'b0;
      icache_req_q <= 1'b0;
    end else if (!stall_o) begin
      valid_q      <= in_valid;
      icache_req_q <= in_icache_req;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush_i && !stall_o) begin
      pc_q         <= in_pc;
      pred_valid_q <= in_pred_valid;
      pred_slot_q  <= in_pred_slot;
      pred_pc_q    <= in_pred_pc;
      excp_q       <= excp_in;
    end
  end

  assign icache_wait = valid_q & ~excp_q.valid & icache_req_q & ~icache_data_valid;
  assign stall_o     = stall_i | icache_wait;
  assign fire        = valid_q & ~stall_o;

  // ---- per-slot predecode and first-redirect search
  assign base = pc_q & ~OFF_MASK;
  assign s0   = (FETCH_W > 1) ? pc_q[2 +: SW] : '0;

  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      inst[i]    = icache_data[32*i +: 32];
      slot_pc[i] = base + 32'(4 * i);
      pd[i]      = predecode(inst[i]);
    end
  end

  // Slots past a valid in-range prediction are never executed, so they raise no events.
  always_comb begin
    hit      = 1'b0;
    bp_hit   = 1'b0;
    call_hit = 1'b0;
    ret_hit  = 1'b0;
    red_pred = 1'b0;
    k        = s0;
    red_pc   = '0;
    bp_pc    = '0;
    link_pc  = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      if (!hit && !excp_q.valid && (i >= int'(s0)) &&
          (!pred_valid_q || (pred_slot_q < s0) || (i <= int'(pred_slot_q)))) begin
        if (pred_valid_q && (((SW'(i) == pred_slot_q) && !pd[i].is_br) ||
                             ((pred_slot_q < s0) && (SW'(i) == s0)))) begin
          hit    = 1'b1;
          bp_hit = 1'b1;
          k      = SW'(i);
          bp_pc  = slot_pc[i];
          red_pc = slot_pc[i] + 32'd4;
        end else if (pd[i].is_b_bl) begin
          hit      = 1'b1;
          k        = SW'(i);
          call_hit = pd[i].is_call;
          link_pc  = slot_pc[i] + 32'd4;
          red_pc   = slot_pc[i] + b_offset(inst[i][25:0]);
        end else if (pd[i].is_ret && ras_valid) begin
          hit      = 1'b1;
          ret_hit  = 1'b1;
          red_pred = 1'b1;
          k        = SW'(i);
          red_pc   = ras_top;
        end
      end
    end
  end

  always_comb begin
    if (excp_q.valid)      last = s0;
    else if (hit)          last = k;
    else if (pred_valid_q) last = pred_slot_q;
    else                   last = SW'(FETCH_W - 1);
    for (int i = 0; i < FETCH_W; i++)
      mask[i] = (i >= int'(s0)) && (i <= int'(last));

    if (excp_q.valid) begin
      next_pc   = pred_valid_q ? pred_pc_q : pc_q + 32'd4;
      next_pred = pred_valid_q;
    end else if (hit) begin
      next_pc   = red_pc;
      next_pred = red_pred;
    end else if (pred_valid_q) begin
      next_pc   = pred_pc_q;
      next_pred = 1'b1;
    end else begin
      next_pc   = base + 32'(4 * FETCH_W);
      next_pred = 1'b0;
    end
  end

`ifdef FETCH2_RAS_EN
  logic ras_push, ras_pop;
  assign ras_push = fire & call_hit;
  assign ras_pop  = fire & ret_hit;

  ras_circ #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_addr_i (link_pc),
    .top_o       (ras_top),
    .top_valid_o (ras_valid)
  );
`else
  logic unused_ras;
  assign ras_top    = '0;
  assign ras_valid  = 1'b0;
  assign unused_ras = ^{call_hit, ret_hit, link_pc, 1'(RAS_DEPTH)};
`endif

  // ---- outputs are single-cycle pulses qualified by fire
  assign out_valid           = fire;
  assign out_pc              = fire ? pc_q : '0;
  assign out_slot_mask       = fire ? mask : '0;
  assign out_inst            = fire ? icache_data : '0;
  assign out_next_pc         = fire ? next_pc : '0;
  assign out_next_is_predict = fire & next_pred;
  assign excp_out            = fire ? excp_q : '0;
  assign bp_update_flush     = fire & hit;

  always_comb begin
    wr_pc_req   = '0;
    btb_invalid = '0;
    if (fire && hit) begin
      wr_pc_req.valid      = 1'b1;
      wr_pc_req.pc         = red_pc;
      wr_pc_req.is_predict = red_pred;
    end
    if (fire && bp_hit) begin
      btb_invalid.valid = 1'b1;
      btb_invalid.pc    = bp_pc;
    end
  end

endmodule

// File: tb/tb_fetch2_wide.sv
// Directed bench for fetch2_wide (FETCH_W=2, RAS_DEPTH=8); RAS steps follow FETCH2_RAS_EN.
module tb_fetch2_wide;
  import fetch2_wide_pkg::*;

  localparam logic [31:0] NOP = 32'h0340_0000;
  localparam logic [31:0] BR  = 32'h5000_0800;
  localparam logic [31:0] BLI = 32'h5401_0000;
  localparam logic [31:0] RET = 32'h4C00_0020;
  localparam logic [31:0] BEQ = 32'h5800_0400;

  logic         clk = 1'b0;
  logic         rst_n, flush_i, stall_i, stall_o;
  logic [63:0]  icache_data;
  logic         icache_data_valid, in_valid, in_icache_req, in_pred_valid;
  logic [31:0]  in_pc, in_pred_pc;
  logic [0:0]   in_pred_slot;
  excp_pass_t   excp_in, excp_out;
  logic         out_valid, out_next_is_predict, bp_update_flush;
  logic [31:0]  out_pc, out_next_pc;
  logic [1:0]   out_slot_mask;
  logic [63:0]  out_inst;
  wr_pc_req_t   wr_pc_req;
  btb_invalid_t btb_invalid;
  excp_pass_t   ex;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  fetch2_wide #(.FETCH_W(2), .RAS_DEPTH(8)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flush_i             (flush_i),
    .stall_i             (stall_i),
    .stall_o             (stall_o),
    .icache_data         (icache_data),
    .icache_data_valid   (icache_data_valid),
    .in_valid            (in_valid),
    .in_pc               (in_pc),
    .in_icache_req       (in_icache_req),
    .in_pred_valid       (in_pred_valid),
    .in_pred_slot        (in_pred_slot),
    .in_pred_pc          (in_pred_pc),
    .excp_in             (excp_in),
    .out_valid           (out_valid),
    .out_pc              (out_pc),
    .out_slot_mask       (out_slot_mask),
    .out_inst            (out_inst),
    .out_next_pc         (out_next_pc),
    .out_next_is_predict (out_next_is_predict),
    .excp_out            (excp_out),
    .wr_pc_req           (wr_pc_req),
    .btb_invalid         (btb_invalid),
    .bp_update_flush     (bp_update_flush)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a packet from fetch1, clocks it in, then drives its icache response.
  task automatic pkt(input logic [31:0] pc, input logic req, input logic pv, input logic ps,
                     input logic [31:0] ppc, input excp_pass_t e,
                     input logic [31:0] d1, input logic [31:0] d0, input logic dv);
    in_valid      = 1'b1;
    in_pc         = pc;
    in_icache_req = req;
    in_pred_valid = pv;
    in_pred_slot  = ps;
    in_pred_pc    = ppc;
    excp_in       = e;
    @(posedge clk);
    #1;
    in_valid          = 1'b0;
    excp_in           = '0;
    icache_data       = {d1, d0};
    icache_data_valid = dv;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
    icache_data = '0; icache_data_valid = 1'b0;
    in_valid = 1'b0; in_pc = '0; in_icache_req = 1'b0;
    in_pred_valid = 1'b0; in_pred_slot = '0; in_pred_pc = '0; excp_in = '0;
    ex = '0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_stall_o", 64'(stall_o), 64'd0);
    chk("rst_wr_pc_req", 64'(wr_pc_req), 64'd0);
    chk("rst_btb_invalid", 64'(btb_invalid), 64'd0);
    chk("rst_bp_flush", 64'(bp_update_flush), 64'd0);
    chk("rst_mask", 64'(out_slot_mask), 64'd0);
    stall_i = 1'b1;
    #1;
    chk("rst_stall_passthru", 64'(stall_o), 64'd1);
    stall_i = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // B in slot 1, no prediction
    pkt(32'h1C00_0000, 1'b1, 1'b0, 1'b0, 32'h0, '0, BR, NOP, 1'b1);
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_out_pc", 64'(out_pc), 64'h1C00_0000);
    chk("t1_mask", 64'(out_slot_mask), 64'b11);
    chk("t1_inst", out_inst, {BR, NOP});
    chk("t1_req_valid", 64'(wr_pc_req.valid), 64'd1);
    chk("t1_req_pc", 64'(wr_pc_req.pc), 64'h1C00_000C);
    chk("t1_req_pred", 64'(wr_pc_req.is_predict), 64'd0);
    chk("t1_bp_flush", 64'(bp_update_flush), 64'd1);
    chk("t1_btb_inv", 64'(btb_invalid.valid), 64'd0);
    chk("t1_next_pc", 64'(out_next_pc), 64'h1C00_000C);

    // BTB predicted a nop at slot 1
    pkt(32'h1C00_0004, 1'b1, 1'b1, 1'b1, 32'h1C00_0100, '0, NOP, BR, 1'b1);
    chk("t2_btb_valid", 64'(btb_invalid.valid), 64'd1);
    chk("t2_btb_pc", 64'(btb_invalid.pc), 64'h1C00_0004);
    chk("t2_req_pc", 64'(wr_pc_req.pc), 64'h1C00_0008);
    chk("t2_req_pred", 64'(wr_pc_req.is_predict), 64'd0);
    chk("t2_mask", 64'(out_slot_mask), 64'b10);

    // correct prediction on BEQ in slot 0; the B behind it is dropped
    pkt(32'h1C00_0000, 1'b1, 1'b1, 1'b0, 32'h1C00_0200, '0, BR, BEQ, 1'b1);
    chk("t3_req_valid", 64'(wr_pc_req.valid), 64'd0);
    chk("t3_mask", 64'(out_slot_mask), 64'b01);
    chk("t3_next_pc", 64'(out_next_pc), 64'h1C00_0200);
    chk("t3_next_pred", 64'(out_next_is_predict), 64'd1);

    // BL at slot 0, then a return at the call target
    pkt(32'h1C00_0000, 1'b1, 1'b0, 1'b0, 32'h0, '0, NOP, BLI, 1'b1);
    chk("t4_bl_req_pc", 64'(wr_pc_req.pc), 64'h1C00_0100);
    chk("t4_bl_mask", 64'(out_slot_mask), 64'b01);
    pkt(32'h1C00_0100, 1'b1, 1'b0, 1'b0, 32'h0, '0, NOP, RET, 1'b1);
`ifdef FETCH2_RAS_EN
    chk("t4_ret_req_valid", 64'(wr_pc_req.valid), 64'd1);
    chk("t4_ret_req_pc", 64'(wr_pc_req.pc), 64'h1C00_0004);
    chk("t4_ret_req_pred", 64'(wr_pc_req.is_predict), 64'd1);
    chk("t4_ret_mask", 64'(out_slot_mask), 64'b01);
`else
    chk("t4_ret_req_valid", 64'(wr_pc_req.valid), 64'd0);
    chk("t4_ret_mask", 64'(out_slot_mask), 64'b11);
    chk("t4_ret_next_pc", 64'(out_next_pc), 64'h1C00_0108);
`endif

    // pred_slot below the start slot is a BTB error at the start slot
    pkt(32'h1C00_0004, 1'b1, 1'b1, 1'b0, 32'h1C00_0300, '0, BR, NOP, 1'b1);
    chk("t5_btb_pc", 64'(btb_invalid.pc), 64'h1C00_0004);
    chk("t5_req_pc", 64'(wr_pc_req.pc), 64'h1C00_0008);
    chk("t5_mask", 64'(out_slot_mask), 64'b10);

    // icache miss for three cycles
    pkt(32'h1C00_0008, 1'b1, 1'b0, 1'b0, 32'h0, '0, NOP, NOP, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk("t6_wait_stall", 64'(stall_o), 64'd1);
      chk("t6_wait_valid", 64'(out_valid), 64'd0);
      if (c < 2) tick();
    end
    icache_data_valid = 1'b1;
    #1;
    chk("t6_fire_valid", 64'(out_valid), 64'd1);
    chk("t6_fire_stall", 64'(stall_o), 64'd0);
    chk("t6_fire_next", 64'(out_next_pc), 64'h1C00_0010);
    tick();

    // flush while waiting on the icache
    pkt(32'h1C00_0010, 1'b1, 1'b0, 1'b0, 32'h0, '0, BR, BR, 1'b0);
    chk("t7_wait_stall", 64'(stall_o), 64'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    chk("t7_flushed_valid", 64'(out_valid), 64'd0);
    chk("t7_flushed_stall", 64'(stall_o), 64'd0);
    icache_data_valid = 1'b1;
    #1;
    chk("t7_late_data", 64'(out_valid), 64'd0);

    // downstream stall holds a start-slot-1 packet
    pkt(32'h1C00_001C, 1'b1, 1'b0, 1'b0, 32'h0, '0, NOP, NOP, 1'b1);
    stall_i = 1'b1;
    #1;
    chk("t8_stall_o", 64'(stall_o), 64'd1);
    chk("t8_stalled_valid", 64'(out_valid), 64'd0);
    tick();
    chk("t8_held_valid", 64'(out_valid), 64'd0);
    stall_i = 1'b0;
    #1;
    chk("t8_release_valid", 64'(out_valid), 64'd1);
    chk("t8_mask", 64'(out_slot_mask), 64'b10);
    chk("t8_next_pc", 64'(out_next_pc), 64'h1C00_0020);

    // exception packet containing a B: no redirect, no cache wait
    ex.valid = 1'b1;
    ex.ecode = 6'h08;
    pkt(32'h1C00_0000, 1'b1, 1'b0, 1'b0, 32'h0, ex, NOP, BR, 1'b0);
    chk("t9_out_valid", 64'(out_valid), 64'd1);
    chk("t9_excp_out", 64'(excp_out), 64'(ex));
    chk("t9_req_valid", 64'(wr_pc_req.valid), 64'd0);
    chk("t9_btb_valid", 64'(btb_invalid.valid), 64'd0);
    chk("t9_mask", 64'(out_slot_mask), 64'b01);
    chk("t9_next_pc", 64'(out_next_pc), 64'h1C00_0004);

`ifdef FETCH2_RAS_EN
    // nine calls into an eight-entry stack, then nine returns
    for (int j = 0; j < 9; j++)
      pkt(32'h1C00_1000 + 32'(16 * j), 1'b1, 1'b0, 1'b0, 32'h0, '0, NOP, BLI, 1'b1);
    for (int r = 0; r < 9; r++) begin
      pkt(32'h1C00_2000, 1'b1, 1'b0, 1'b0, 32'h0, '0, NOP, RET, 1'b1);
      if (r < 8) begin
        chk("ras_ret_valid", 64'(wr_pc_req.valid), 64'd1);
        chk("ras_ret_pc", 64'(wr_pc_req.pc), 64'h1C00_1004 + 64'(16 * (8 - r)));
        chk("ras_ret_pred", 64'(wr_pc_req.is_predict), 64'd1);
      end else begin
        chk("ras_empty_valid", 64'(wr_pc_req.valid), 64'd0);
      end
    end
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
